// File: rtl/propagate_assignment_pkg.sv
// Shared CNF types, constants and FSM state enum for the multi-literal propagator.
// Used by propagate_assignment and propagate_assignment_lit_match.
package propagate_assignment_pkg;

  localparam int width_num         = 4;
  localparam int width_litarray    = 2;
  localparam int width_clausearray = 2;
  localparam int max_lits          = 2 ** width_litarray;
  localparam int max_clauses       = 2 ** width_clausearray;
  localparam int default_num_assign = 4;

  // num == 0 marks an unused literal / assignment slot
  typedef struct packed {
    logic [width_num-1:0] num;
    logic                 val;
  } lit;

  typedef struct packed {
    lit [max_lits-1:0]       lits;
    logic [width_litarray:0] len;
  } clause;

  typedef struct packed {
    clause [max_clauses-1:0]    clauses;
    logic [width_clausearray:0] len;
  } formula;

  localparam lit     zero_lit     = '0;
  localparam clause  zero_clause  = '0;
  localparam formula zero_formula = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLAUSE_BEGIN,
    ST_SCAN,
    ST_CLAUSE_END,
    ST_FINISH
  } pa_state_e;

endpackage

// File: rtl/propagate_assignment_lit_match.sv
// Combinational match of one literal against every valid assignment slot.
// sat_hit: same num and val in some slot; neg_hit: same num, opposite val.
module propagate_assignment_lit_match
  import propagate_assignment_pkg::*;
#(
  parameter int NUM_ASSIGN = default_num_assign
) (
  input  lit                  lit_i,
  input  lit [NUM_ASSIGN-1:0] slots_i,
  output logic                sat_hit,
  output logic                neg_hit
);

  always_comb begin
    sat_hit = 1'b0;
    neg_hit = 1'b0;
    for (int k = 0; k < NUM_ASSIGN; k++) begin
      if ((slots_i[k].num != '0) && (slots_i[k].num == lit_i.num)) begin
        if (slots_i[k].val == lit_i.val) sat_hit = 1'b1;
        else                             neg_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/propagate_assignment.sv
// Applies up to NUM_ASSIGN literal assignments to a CNF formula in one pass.
// Optional unit-clause detection is built when PROPAGATE_UNIT_DETECT_EN is defined.
//   state        | meaning
//   IDLE         | waiting for find (ignored while ended is high)
//   LOAD         | pairwise check of assignment slots for conflicts
//   CLAUSE_BEGIN | select clause i or finish
//   SCAN         | one literal of clause i per cycle
//   CLAUSE_END   | store surviving clause or abort on empty clause
//   FINISH       | publish result, pulse ended next cycle
module propagate_assignment
  import propagate_assignment_pkg::*;
#(
  parameter int NUM_ASSIGN = default_num_assign
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                find,
  input  lit [NUM_ASSIGN-1:0] in_lits,
  input  formula              in_formula,
  output logic                ended,
  output logic                empty_clause,
  output logic                empty_formula,
  output logic                assign_conflict,
  output logic                unit_found,
  output lit                  unit_lit,
  output formula              out_formula
);

  pa_state_e                  state_q, state_d;
  formula                     form_q, form_d;
  lit [NUM_ASSIGN-1:0]        lits_q, lits_d;
  formula                     work_q, work_d;
  clause                      tmp_q, tmp_d;
  logic [width_clausearray:0] i_q, i_d;
  logic [width_litarray:0]    j_q, j_d;
  logic                       ended_q, ended_d;
  logic                       empty_clause_q, empty_clause_d;
  logic                       empty_formula_q, empty_formula_d;
  logic                       conflict_q, conflict_d;
  formula                     out_formula_q, out_formula_d;
`ifdef PROPAGATE_UNIT_DETECT_EN
  logic                       unit_found_q, unit_found_d;
  lit                         unit_lit_q, unit_lit_d;
`endif

  clause cur_clause;
  lit    cur_lit;
  logic  scan_sat, scan_neg;
  logic  pair_conflict;
  logic [NUM_ASSIGN-1:0] pair_neg;
  logic [NUM_ASSIGN-1:0] pair_sat_unused;

  assign cur_clause = form_q.clauses[i_q[width_clausearray-1:0]];
  assign cur_lit    = cur_clause.lits[j_q[width_litarray-1:0]];

  propagate_assignment_lit_match #(.NUM_ASSIGN(NUM_ASSIGN)) u_scan (
    .lit_i   (cur_lit),
    .slots_i (lits_q),
    .sat_hit (scan_sat),
    .neg_hit (scan_neg)
  );

  // each slot against all slots; a slot never conflicts with itself
  for (genvar g = 0; g < NUM_ASSIGN; g++) begin : g_pair
    propagate_assignment_lit_match #(.NUM_ASSIGN(NUM_ASSIGN)) u_pair (
      .lit_i   (lits_q[g]),
      .slots_i (lits_q),
      .sat_hit (pair_sat_unused[g]),
      .neg_hit (pair_neg[g])
    );
  end

  assign pair_conflict = |pair_neg;

  always_comb begin
    state_d         = state_q;
    form_d          = form_q;
    lits_d          = lits_q;
    work_d          = work_q;
    tmp_d           = tmp_q;
    i_d             = i_q;
    j_d             = j_q;
    ended_d         = 1'b0;
    empty_clause_d  = empty_clause_q;
    empty_formula_d = empty_formula_q;
    conflict_d      = conflict_q;
    out_formula_d   = out_formula_q;
`ifdef PROPAGATE_UNIT_DETECT_EN
    unit_found_d    = unit_found_q;
    unit_lit_d      = unit_lit_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (find && !ended_q) begin
          form_d          = in_formula;
          lits_d          = in_lits;
          work_d          = zero_formula;
          i_d             = '0;
          empty_clause_d  = 1'b0;
          empty_formula_d = 1'b0;
          conflict_d      = 1'b0;
`ifdef PROPAGATE_UNIT_DETECT_EN
          unit_found_d    = 1'b0;
          unit_lit_d      = zero_lit;
`endif
          state_d         = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (pair_conflict) begin
          conflict_d     = 1'b1;
          empty_clause_d = 1'b1;
          state_d        = ST_FINISH;
        end else begin
          state_d = ST_CLAUSE_BEGIN;
        end
      end

      ST_CLAUSE_BEGIN: begin
        if (i_q >= form_q.len) begin
          state_d = ST_FINISH;
        end else begin
          tmp_d   = zero_clause;
          j_d     = '0;
          state_d = (cur_clause.len == '0) ? ST_CLAUSE_END : ST_SCAN;
        end
      end

      ST_SCAN: begin
        if ((cur_lit.num != '0) && scan_sat) begin
          i_d     = i_q + 1'b1;
          state_d = ST_CLAUSE_BEGIN;
        end else begin
          if ((cur_lit.num != '0) && !scan_neg) begin
            tmp_d.lits[tmp_q.len[width_litarray-1:0]] = cur_lit;
            tmp_d.len = tmp_q.len + 1'b1;
          end
          j_d = j_q + 1'b1;
          if ((j_q + 1'b1) >= cur_clause.len) state_d = ST_CLAUSE_END;
        end
      end

      ST_CLAUSE_END: begin
        if (tmp_q.len == '0) begin
          empty_clause_d = 1'b1;
          state_d        = ST_FINISH;
        end else begin
          work_d.clauses[work_q.len[width_clausearray-1:0]] = tmp_q;
          work_d.len = work_q.len + 1'b1;
          i_d        = i_q + 1'b1;
`ifdef PROPAGATE_UNIT_DETECT_EN
          if (!unit_found_q && (tmp_q.len == 1)) begin
            unit_found_d = 1'b1;
            unit_lit_d   = tmp_q.lits[0];
          end
`endif
          state_d = ST_CLAUSE_BEGIN;
        end
      end

      ST_FINISH: begin
        ended_d         = 1'b1;
        out_formula_d   = work_q;
        empty_formula_d = (work_q.len == '0) && !empty_clause_q;
        state_d         = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      form_q          <= zero_formula;
      lits_q          <= '0;
      work_q          <= zero_formula;
      tmp_q           <= zero_clause;
      i_q             <= '0;
      j_q             <= '0;
      ended_q         <= 1'b0;
      empty_clause_q  <= 1'b0;
      empty_formula_q <= 1'b0;
      conflict_q      <= 1'b0;
      out_formula_q   <= zero_formula;
`ifdef PROPAGATE_UNIT_DETECT_EN
      unit_found_q    <= 1'b0;
      unit_lit_q      <= zero_lit;
`endif
    end else begin
      state_q         <= state_d;
      form_q          <= form_d;
      lits_q          <= lits_d;
      work_q          <= work_d;
      tmp_q           <= tmp_d;
      i_q             <= i_d;
      j_q             <= j_d;
      ended_q         <= ended_d;
      empty_clause_q  <= empty_clause_d;
      empty_formula_q <= empty_formula_d;
      conflict_q      <= conflict_d;
      out_formula_q   <= out_formula_d;
`ifdef PROPAGATE_UNIT_DETECT_EN
      unit_found_q    <= unit_found_d;
      unit_lit_q      <= unit_lit_d;
`endif
    end
  end

  assign ended           = ended_q;
  assign empty_clause    = empty_clause_q;
  assign empty_formula   = empty_formula_q;
  assign assign_conflict = conflict_q;
  assign out_formula     = out_formula_q;
`ifdef PROPAGATE_UNIT_DETECT_EN
  assign unit_found      = unit_found_q;
  assign unit_lit        = unit_lit_q;
`else
  assign unit_found      = 1'b0;
  assign unit_lit        = zero_lit;
`endif

endmodule
